// File: rtl/cpu_run_ctrl.sv
// Core run controller: synchronizes reset release, then releases N_CH core resets in a
// staggered order and tracks halts/cycles. Define RUN_CTRL_WATCHDOG_EN for the watchdog.
module cpu_run_ctrl #(
    parameter int unsigned N_CH           = 1,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned STAGGER        = 1,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  halt_req,
    input  logic             restart,
    output logic [N_CH-1:0]  core_reset,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [N_CH-1:0]  halted,
    output logic             done,
    output logic             timeout
);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned IW = $clog2(N_CH + 1);

    typedef enum logic [2:0] {S_RST, S_HOLD, S_REL, S_RUN, S_DONE, S_TOUT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [HW-1:0]     hold_q, hold_d;
    logic [SW-1:0]     stag_q, stag_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_CH-1:0]   core_reset_q, core_reset_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   halted_q, halted_d;
    logic [N_CH-1:0]   halted_all;
    logic              all_halted;
    logic              wd_fire;

    // Halts only count from channels already out of reset.
    assign halted_all = halted_q | (halt_req & ~core_reset_q);
    assign all_halted = &halted_all;

`ifdef RUN_CTRL_WATCHDOG_EN
    assign wd_fire = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timeout = (state_q == S_TOUT);
`else
    // Constant 0; the watchdog is compiled out.
    assign wd_fire = 1'b0 && (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        stag_d       = stag_q;
        idx_d        = idx_q;
        core_reset_d = core_reset_q;
        cnt_d        = cnt_q;
        halted_d     = halted_q;
        unique case (state_q)
            S_RST: begin
                core_reset_d = '1;
                if (sync_q[1]) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                core_reset_d = '1;
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d         = S_REL;
                    core_reset_d[0] = 1'b0;
                    idx_d           = IW'(1);
                    stag_d          = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_REL, S_RUN: begin
                halted_d = halted_all;
                if (state_q == S_REL) begin
                    if (idx_q == IW'(N_CH)) begin
                        state_d = S_RUN;
                    end else if (stag_q == SW'(STAGGER - 1)) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (idx_q == IW'(i)) core_reset_d[i] = 1'b0;
                        end
                        idx_d  = idx_q + IW'(1);
                        stag_d = '0;
                    end else begin
                        stag_d = stag_q + SW'(1);
                    end
                end
                // Completion has priority over an expiring watchdog.
                if (all_halted) begin
                    state_d = S_DONE;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else if (wd_fire) begin
                    state_d      = S_TOUT;
                    core_reset_d = '1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_TOUT: begin
                if (state_q == S_TOUT) core_reset_d = '1;
                if (restart) begin
                    state_d      = S_HOLD;
                    hold_d       = '0;
                    cnt_d        = '0;
                    halted_d     = '0;
                    core_reset_d = '1;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RST;
            sync_q       <= 2'b00;
            hold_q       <= '0;
            stag_q       <= '0;
            idx_q        <= '0;
            core_reset_q <= '1;
            cnt_q        <= '0;
            halted_q     <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], 1'b1};
            hold_q       <= hold_d;
            stag_q       <= stag_d;
            idx_q        <= idx_d;
            core_reset_q <= core_reset_d;
            cnt_q        <= cnt_d;
            halted_q     <= halted_d;
        end
    end

    assign core_reset = core_reset_q;
    assign cycle_cnt  = cnt_q;
    assign halted     = halted_q;
    assign done       = (state_q == S_DONE);
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter N_CH, default 1, number of independently released core reset channels (1..8).
REQ-002 Parameter HOLD_CYCLES, default 2, cycles all core resets stay asserted after synchronized reset release (>=1).
REQ-003 Parameter STAGGER, default 1, cycles between successive channel releases (>=1).
REQ-004 Parameter CNT_W, default 32, width of cycle counter.
REQ-005 Parameter TIMEOUT_CYCLES, default 10000, cycle_cnt value triggering timeout (<2^CNT_W).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 halt_req  input  N_CH  per-channel "core finished" level/pulse.
REQ-009 restart  input  1  single-cycle request to re-run after DONE/TOUT.
REQ-010 core_reset  output  N_CH  active-high synchronous reset to each core channel.
REQ-011 cycle_cnt  output  CNT_W  cycles elapsed since first channel release.
REQ-012 halted  output  N_CH  sticky per-channel halt mask.
REQ-013 done  output  1  all channels halted.
REQ-014 timeout  output  1  watchdog expired.

Function
REQ-015 Reset deassertion SHALL pass a 2-flop synchronizer; assertion SHALL act immediately.
REQ-016 FSM states SHALL be S_RST, S_HOLD, S_REL, S_RUN, S_DONE, S_TOUT.
REQ-017 S_RST: all core_reset=1; leaves to S_HOLD on first cycle synchronized reset is inactive.
REQ-018 S_HOLD: count HOLD_CYCLES cycles with all core_reset=1, then S_REL.
REQ-019 S_REL: clear core_reset[0] on entry, then next index every STAGGER cycles, ascending; after bit N_CH-1 clears, S_RUN.
REQ-020 N_CH=1: S_REL lasts one cycle.
REQ-021 Released core_reset bit SHALL stay 0 until S_TOUT, restart, or reset.
REQ-022 cycle_cnt SHALL clear on S_HOLD entry, increment each cycle in S_REL/S_RUN, saturate at all-ones, freeze in S_DONE/S_TOUT.
REQ-023 halted[i] SHALL set when halt_req[i]=1 and core_reset[i]=0 that cycle; halt_req from unreleased channel ignored.
REQ-024 When all halted bits are 1 (including bits setting this cycle), next state S_DONE; done=1 there.
REQ-025 S_DONE: core_reset unchanged (halted cores stay out of reset).
REQ-026 restart=1 in S_DONE or S_TOUT SHALL go to S_HOLD, clear halted, done, timeout, cycle_cnt; restart ignored in other states.
REQ-027 Halt completion and timeout in same cycle: done wins, S_DONE.
REQ-028 done and timeout SHALL never both be 1.

Reset
REQ-029 On reset low: state S_RST, core_reset all 1, cycle_cnt 0, halted 0, done 0, timeout 0, synchronizer flops 0.
REQ-030 Reset asserted mid-operation in any state SHALL apply REQ-029 asynchronously.

Configuration
REQ-031 Macro RUN_CTRL_WATCHDOG_EN defined: in S_REL/S_RUN, cycle_cnt==TIMEOUT_CYCLES with not all halted -> S_TOUT, timeout=1, all core_reset=1.
REQ-032 Macro undefined: no watchdog logic, S_TOUT unreachable, timeout tied 0, TIMEOUT_CYCLES ignored.

Verification
REQ-033 N_CH=1, HOLD=2: reset low 3 cycles then high -> core_reset[0] falls exactly 2 sync + 2 hold + 1 cycles after release edge; cycle_cnt starts counting from 0.
REQ-034 N_CH=4, STAGGER=3: core_reset goes 1111->1110->1100->1000->0000 at 3-cycle spacing; S_RUN after last.
REQ-035 N_CH=2: halt_req=01 at cycle 10, 10 at cycle 20 -> halted=11, done=1 cycle after 20, cycle_cnt frozen at 21; halt_req=10 pulsed during S_HOLD ignored.
REQ-036 Watchdog on, TIMEOUT_CYCLES=50, no halts -> timeout=1 at cycle_cnt=50, core_reset all 1; restart -> S_HOLD, timeout 0, cycle_cnt 0.
REQ-037 Last halt and cycle_cnt==TIMEOUT_CYCLES same cycle -> done=1, timeout=0.
REQ-038 Reset pulsed low mid S_RUN with cycle_cnt=37 -> all outputs at reset values immediately, sequence restarts on release.
